// File: rtl/perceptron_neuron_pkg.sv
// Shared widths, saturation limits and FSM encodings for the two-input perceptron trainer.
package perceptron_neuron_pkg;

    localparam int X_W   = 7;
    localparam int W_W   = 14;
    localparam int ACC_W = 23;

    localparam logic signed [W_W-1:0] WMAX = 14'sh1FFF;
    localparam logic signed [W_W-1:0] WMIN = 14'sh2000;

    typedef logic [2:0]        state_t;
    typedef logic signed [1:0] bipolar_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_INIT    = 3'd1;
    localparam state_t S_REQ     = 3'd2;
    localparam state_t S_CALC    = 3'd3;
    localparam state_t S_UPDATE  = 3'd4;
    localparam state_t S_RELEASE = 3'd5;
    localparam state_t S_DONE    = 3'd6;

    localparam bipolar_t POS_ONE = 2'sb01;
    localparam bipolar_t NEG_ONE = 2'sb11;
    localparam bipolar_t ZERO    = 2'sb00;

endpackage

// File: rtl/perceptron_neuron_mac.sv
// Combinational datapath: net input, thresholded activation and saturating Fausett updates.
module perceptron_mac
    import perceptron_neuron_pkg::*;
#(
    parameter int THETA = 0
) (
    input  logic signed [W_W-1:0]   w1,
    input  logic signed [W_W-1:0]   w2,
    input  logic signed [W_W-1:0]   b,
    input  logic signed [X_W-1:0]   x1,
    input  logic signed [X_W-1:0]   x2,
    input  bipolar_t                t,
    input  logic signed [ACC_W-1:0] yin_q,
    output logic signed [ACC_W-1:0] yin,
    output logic                    mismatch,
    output logic signed [W_W-1:0]   w1_next,
    output logic signed [W_W-1:0]   w2_next,
    output logic signed [W_W-1:0]   b_next
);

    localparam int P_W = W_W + X_W;
    localparam logic signed [ACC_W-1:0] THETA_S = ACC_W'(THETA);

    function automatic bipolar_t activate(input logic signed [ACC_W-1:0] v);
        bipolar_t y;
        if (v > THETA_S) begin
            y = POS_ONE;
        end else if (v < -THETA_S) begin
            y = NEG_ONE;
        end else begin
            y = ZERO;
        end
        return y;
    endfunction

    // t is already normalised to +1/-1, so the product is just a conditional negate.
    function automatic logic signed [X_W:0] scale(input bipolar_t tt, input logic signed [X_W-1:0] x);
        logic signed [X_W:0] xe;
        logic signed [X_W:0] r;
        xe = {x[X_W-1], x};
        if (tt == POS_ONE) begin
            r = xe;
        end else begin
            r = -xe;
        end
        return r;
    endfunction

    function automatic logic signed [W_W-1:0] sat_add(input logic signed [W_W-1:0] w,
                                                      input logic signed [X_W:0]   d);
        logic signed [W_W:0]   s;
        logic signed [W_W-1:0] r;
        s = $signed({w[W_W-1], w}) + $signed({{(W_W-X_W){d[X_W]}}, d});
        if (s > $signed({WMAX[W_W-1], WMAX})) begin
            r = WMAX;
        end else if (s < $signed({WMIN[W_W-1], WMIN})) begin
            r = WMIN;
        end else begin
            r = s[W_W-1:0];
        end
        return r;
    endfunction

    logic signed [P_W-1:0] p1_s;
    logic signed [P_W-1:0] p2_s;
    logic signed [X_W:0]   db_s;

    // Full-precision net input plus candidate next weights for the UPDATE cycle.
    always_comb begin
        p1_s     = P_W'(w1) * P_W'(x1);
        p2_s     = P_W'(w2) * P_W'(x2);
        yin      = ACC_W'(b) + ACC_W'(p1_s) + ACC_W'(p2_s);
        mismatch = (activate(yin_q) != t);
        if (t == POS_ONE) begin
            db_s = 8'sd1;
        end else begin
            db_s = -8'sd1;
        end
        w1_next  = sat_add(w1, scale(t, x1));
        w2_next  = sat_add(w2, scale(t, x2));
        b_next   = sat_add(b, db_s);
    end

endmodule

// File: rtl/perceptron_neuron.sv
// Perceptron trainer top: sample handshake FSM, epoch/sample counters and weight registers.
module perceptron_neuron
    import perceptron_neuron_pkg::*;
#(
    parameter int THETA      = 0,
    parameter int MAX_EPOCHS = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           n,
    input  logic signed [X_W-1:0] x1,
    input  logic signed [X_W-1:0] x2,
    input  logic signed [1:0]     t,
    input  logic                  dataReady,
    output logic                  requestFlag,
    output logic                  done,
    output logic signed [W_W-1:0] w1,
    output logic signed [W_W-1:0] w2,
    output logic signed [W_W-1:0] b
);

    localparam logic [31:0] EPOCH_LIMIT = 32'(MAX_EPOCHS);

    state_t                  state_r;
    logic [31:0]             n_r;
    logic [31:0]             count_r;
    logic [31:0]             epoch_r;
    logic                    change_r;
    logic signed [X_W-1:0]   x1_r;
    logic signed [X_W-1:0]   x2_r;
    bipolar_t                t_r;
    logic signed [ACC_W-1:0] yin_r;

    logic signed [ACC_W-1:0] yin_s;
    logic                    mismatch_s;
    logic signed [W_W-1:0]   w1_next_s;
    logic signed [W_W-1:0]   w2_next_s;
    logic signed [W_W-1:0]   b_next_s;

    perceptron_mac #(.THETA(THETA)) u_mac (
        .w1       (w1),
        .w2       (w2),
        .b        (b),
        .x1       (x1_r),
        .x2       (x2_r),
        .t        (t_r),
        .yin_q    (yin_r),
        .yin      (yin_s),
        .mismatch (mismatch_s),
        .w1_next  (w1_next_s),
        .w2_next  (w2_next_s),
        .b_next   (b_next_s)
    );

    // Training FSM with all state, counters, captured sample and weights.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            n_r         <= 32'd0;
            count_r     <= 32'd0;
            epoch_r     <= 32'd0;
            change_r    <= 1'b0;
            x1_r        <= 7'sd0;
            x2_r        <= 7'sd0;
            t_r         <= NEG_ONE;
            yin_r       <= 23'sd0;
            requestFlag <= 1'b0;
            done        <= 1'b0;
            w1          <= 14'sd0;
            w2          <= 14'sd0;
            b           <= 14'sd0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_r     <= n;
                        done    <= 1'b0;
                        state_r <= S_INIT;
                    end
                end
                S_INIT: begin
                    w1       <= 14'sd0;
                    w2       <= 14'sd0;
                    b        <= 14'sd0;
                    count_r  <= 32'd0;
                    epoch_r  <= 32'd0;
                    change_r <= 1'b0;
                    if (n_r == 32'd0) begin
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        requestFlag <= 1'b1;
                        state_r     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dataReady) begin
                        x1_r        <= x1;
                        x2_r        <= x2;
                        t_r         <= (t == POS_ONE) ? POS_ONE : NEG_ONE;
                        requestFlag <= 1'b0;
                        state_r     <= S_CALC;
                    end
                end
                S_CALC: begin
                    yin_r   <= yin_s;
                    state_r <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (mismatch_s) begin
                        w1       <= w1_next_s;
                        w2       <= w2_next_s;
                        b        <= b_next_s;
                        change_r <= 1'b1;
                    end
                    count_r <= count_r + 32'd1;
                    state_r <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Four-phase: the feeder must drop dataReady before the next request.
                    if (!dataReady) begin
                        if (count_r < n_r) begin
                            requestFlag <= 1'b1;
                            state_r     <= S_REQ;
                        end else if (!change_r || (epoch_r + 32'd1 == EPOCH_LIMIT)) begin
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            count_r     <= 32'd0;
                            change_r    <= 1'b0;
                            epoch_r     <= epoch_r + 32'd1;
                            requestFlag <= 1'b1;
                            state_r     <= S_REQ;
                        end
                    end
                end
                default: begin
                    requestFlag <= 1'b0;
                    done        <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_neuron.sv
// Directed bench for perceptron_neuron: AND training, handshake, n=0, mid-epoch reset, saturation.
module tb_perceptron_neuron;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic               rst, start, dataReady;
    logic [31:0]        n;
    logic signed [6:0]  x1, x2;
    logic signed [1:0]  t;
    logic               requestFlag, done;
    logic signed [13:0] w1, w2, b;

    logic               s_rst, s_start, s_dr;
    logic [31:0]        s_n;
    logic signed [6:0]  s_x1, s_x2;
    logic signed [1:0]  s_t;
    logic               s_req, s_done;
    logic signed [13:0] s_w1, s_w2, s_b;
    int                 s_caps;
    int                 guard;

    perceptron_neuron #(.THETA(0), .MAX_EPOCHS(1000)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .x1(x1), .x2(x2), .t(t),
        .dataReady(dataReady), .requestFlag(requestFlag), .done(done),
        .w1(w1), .w2(w2), .b(b)
    );

    // Dead-band wider than any reachable net input: every sample is misclassified.
    perceptron_neuron #(.THETA(4000000), .MAX_EPOCHS(300)) dut_sat (
        .clk(clk), .rst(s_rst), .start(s_start), .n(s_n), .x1(s_x1), .x2(s_x2), .t(s_t),
        .dataReady(s_dr), .requestFlag(s_req), .done(s_done),
        .w1(s_w1), .w2(s_w2), .b(s_b)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int nn);
        n     = nn;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int sx1, input int sx2, input int st, input int hold);
        int cnt;
        cnt = 0;
        while (requestFlag !== 1'b1 && cnt < 200) begin
            step();
            cnt++;
        end
        check("req_raised", requestFlag, 1);
        x1 = sx1[6:0];
        x2 = sx2[6:0];
        t  = st[1:0];
        dataReady = 1'b1;
        step();
        check("req_drop", requestFlag, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            check("req_hold_low", requestFlag, 0);
        end
        dataReady = 1'b0;
        x1 = 7'sh2A;
        x2 = 7'sh55;
        t  = 2'sb00;
    endtask

    task automatic wait_done();
        int cnt;
        cnt = 0;
        while (done !== 1'b1 && cnt < 200) begin
            step();
            cnt++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic check_w(input string tag, input int e1, input int e2, input int eb);
        check({tag, "_w1"}, w1, e1);
        check({tag, "_w2"}, w2, e2);
        check({tag, "_b"},  b,  eb);
    endtask

    task automatic and_epoch();
        feed(1, 1, 1, 0);
        feed(1, -1, -1, 0);
        feed(-1, 1, -1, 0);
        feed(-1, -1, -1, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dataReady = 1'b0; n = 32'd0;
        x1 = 7'sd0; x2 = 7'sd0; t = 2'sb00;
        s_rst = 1'b1; s_start = 1'b0; s_dr = 1'b0; s_n = 32'd0;
        s_x1 = 7'sd0; s_x2 = 7'sd0; s_t = 2'sb00; s_caps = 0;
        repeat (3) step();
        check("rst_req", requestFlag, 0);
        check("rst_done", done, 0);
        check_w("rst", 0, 0, 0);
        rst = 1'b0;
        s_rst = 1'b0;
        step();

        // Bipolar AND with latency check on the first sample.
        do_start(4);
        feed(1, 1, 1, 0);
        step();
        check("lat_calc_w1", w1, 0);
        step();
        check_w("lat_update", 1, 1, 1);
        feed(1, -1, -1, 0);
        feed(-1, 1, -1, 0);
        feed(-1, -1, -1, 0);
        repeat (2) step();
        check_w("and_ep1", 1, 1, -1);
        check("and_ep1_done", done, 0);
        and_epoch();
        wait_done();
        check_w("and_final", 1, 1, -1);
        check("and_final_req", requestFlag, 0);
        dataReady = 1'b1;
        repeat (3) step();
        check("done_ignore_req", requestFlag, 0);
        check_w("done_frozen", 1, 1, -1);
        dataReady = 1'b0;
        step();

        // n=1 with dataReady held 10 cycles after capture.
        do_start(1);
        check("restart_done_clr", done, 0);
        feed(3, -2, -1, 10);
        check_w("n1_ep1", -3, 2, -1);
        step();
        check("req_reraise", requestFlag, 1);
        feed(3, -2, -1, 0);
        wait_done();
        check_w("n1_final", -3, 2, -1);

        // n=0: straight to done, weights cleared, no request.
        do_start(0);
        check("n0_done_clr", done, 0);
        check("n0_req0", requestFlag, 0);
        step();
        check("n0_done", done, 1);
        check_w("n0", 0, 0, 0);
        repeat (3) step();
        check("n0_req_idle", requestFlag, 0);

        // Mid-epoch reset; a stray start mid-run must be ignored.
        do_start(4);
        feed(1, 1, 1, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        feed(1, -1, -1, 0);
        repeat (2) step();
        check_w("mid_two", 0, 2, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_req", requestFlag, 0);
        check("mid_rst_done", done, 0);
        check_w("mid_rst", 0, 0, 0);
        repeat (2) step();
        check("idle_req", requestFlag, 0);
        do_start(4);
        and_epoch();
        and_epoch();
        wait_done();
        check_w("rerun", 1, 1, -1);

        // Saturation to epoch limit.
        s_n = 32'd1; s_x1 = 7'sd63; s_x2 = 7'sd63; s_t = 2'sb01;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        guard = 0;
        while (s_done !== 1'b1 && guard < 5000) begin
            if (s_req && !s_dr) begin
                s_dr = 1'b1;
                s_caps++;
            end else if (!s_req && s_dr) begin
                s_dr = 1'b0;
            end
            step();
            guard++;
        end
        check("sat_done", s_done, 1);
        check("sat_captures", s_caps, 300);
        check("sat_w1", s_w1, 8191);
        check("sat_w2", s_w2, 8191);
        check("sat_b", s_b, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
